// File: rtl/rgb_cmd_ctrl.sv
// Frame parser for SYNC/ADDR/DATA/CHK byte frames from the UART receiver.
// Checksum-verified frames update the RGB duty registers; bad or stalled frames are counted.
module rgb_cmd_ctrl #(
    parameter int unsigned CLK_HZ      = 100_000_000,
    parameter int unsigned TIMEOUT_CYC = CLK_HZ / 1000,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter logic [7:0]  DUTY_RST    = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] command,
    input  logic       rx_valid,
    output logic [7:0] duty_r,
    output logic [7:0] duty_g,
    output logic [7:0] duty_b,
    output logic       cfg_update,
    output logic       frame_err,
    output logic [7:0] err_cnt
);
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, S_ADDR, S_DATA, S_CHK} state_t;

    state_t           state, state_nxt;
    logic [1:0]       addr_q, addr_d;
    logic [7:0]       data_q, data_d;
    logic [TMO_W-1:0] tmo_cnt;
    logic             wr_en, err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            addr_q <= 2'd0;
            data_q <= 8'h00;
        end else begin
            state  <= state_nxt;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    // A received byte always takes priority over a timeout expiring on the same cycle.
    always_comb begin
        state_nxt = state;
        addr_d    = addr_q;
        data_d    = data_q;
        wr_en     = 1'b0;
        err_d     = 1'b0;
        if (rx_valid) begin
            case (state)
                IDLE: if (command == SYNC_BYTE) state_nxt = S_ADDR;
                S_ADDR: begin
                    if (command <= 8'h03) begin
                        addr_d    = command[1:0];
                        state_nxt = S_DATA;
                    end else if (command != SYNC_BYTE) begin
                        err_d     = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                S_DATA: begin
                    data_d    = command;
                    state_nxt = S_CHK;
                end
                S_CHK: begin
                    if (command == ({6'd0, addr_q} ^ data_q)) wr_en = 1'b1;
                    else                                      err_d = 1'b1;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end else if (state != IDLE && tmo_cnt == TMO_W'(TIMEOUT_CYC)) begin
            err_d     = 1'b1;
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (rx_valid || state == IDLE || state_nxt == IDLE) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_r     <= DUTY_RST;
            duty_g     <= DUTY_RST;
            duty_b     <= DUTY_RST;
            cfg_update <= 1'b0;
            frame_err  <= 1'b0;
            err_cnt    <= 8'h00;
        end else begin
            cfg_update <= wr_en;
            frame_err  <= err_d;
            if (wr_en) begin
                // addr 3 broadcasts to all channels
                if (addr_q == 2'd0 || addr_q == 2'd3) duty_r <= data_q;
                if (addr_q == 2'd1 || addr_q == 2'd3) duty_g <= data_q;
                if (addr_q == 2'd2 || addr_q == 2'd3) duty_b <= data_q;
            end
            if (err_d && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'h01;
        end
    end
endmodule

// File: tb/tb_rgb_cmd_ctrl.sv
// Directed bench for rgb_cmd_ctrl: stimulus pushes expected pulses into a scoreboard,
// a negedge monitor pops and compares them against cfg_update/frame_err events.
module tb_rgb_cmd_ctrl;
    localparam int T = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] command = 8'h00;
    logic       rx_valid = 1'b0;
    logic [7:0] duty_r, duty_g, duty_b, err_cnt;
    logic       cfg_update, frame_err;

    rgb_cmd_ctrl #(.TIMEOUT_CYC(T)) dut (
        .clk(clk), .rst_n(rst_n), .command(command), .rx_valid(rx_valid),
        .duty_r(duty_r), .duty_g(duty_g), .duty_b(duty_b),
        .cfg_update(cfg_update), .frame_err(frame_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_err;
        logic [7:0] r, g, b, ec;
        int         cyc;
    } ev_t;

    ev_t        q[$];
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    logic [7:0] m_r = 8'h00, m_g = 8'h00, m_b = 8'h00, m_ec = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: every pulse must match the head of the scoreboard, at the exact cycle.
    always @(negedge clk) begin
        if (rst_n && q.size() != 0 && q[0].cyc < cyc) begin
            chk("missed_pulse_cycle", cyc, q[0].cyc);
            void'(q.pop_front());
        end
        if (rst_n && (cfg_update || frame_err)) begin
            checks++;
            assert (q.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_pulse cfg=%0b err=%0b at cyc=%0d expected no pulse",
                       cfg_update, frame_err, cyc);
            end
            if (q.size() != 0) begin
                ev_t e;
                e = q.pop_front();
                chk("pulse_cycle", cyc, e.cyc);
                chk("pulse_kind_err", {31'd0, frame_err}, {31'd0, e.is_err});
                chk("pulse_kind_cfg", {31'd0, cfg_update}, {31'd0, !e.is_err});
                if (e.is_err) begin
                    chk("err_cnt", {24'd0, err_cnt}, {24'd0, e.ec});
                end else begin
                    chk("duty_r", {24'd0, duty_r}, {24'd0, e.r});
                    chk("duty_g", {24'd0, duty_g}, {24'd0, e.g});
                    chk("duty_b", {24'd0, duty_b}, {24'd0, e.b});
                end
            end
        end
    end

    // All drives happen at negedge; each byte is sampled by the following posedge.
    task automatic send(input logic [7:0] b);
        command  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_err(input int at);
        ev_t e;
        if (m_ec != 8'hFF) m_ec = m_ec + 8'h01;
        e = '{is_err: 1'b1, r: m_r, g: m_g, b: m_b, ec: m_ec, cyc: at};
        q.push_back(e);
    endtask

    // Sends the CHK byte of a frame whose SYNC/ADDR/DATA are already sent.
    task automatic send_chk(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
        ev_t e;
        if (c == (a ^ d)) begin
            if (a == 8'h00 || a == 8'h03) m_r = d;
            if (a == 8'h01 || a == 8'h03) m_g = d;
            if (a == 8'h02 || a == 8'h03) m_b = d;
            e = '{is_err: 1'b0, r: m_r, g: m_g, b: m_b, ec: m_ec, cyc: cyc + 1};
            q.push_back(e);
        end else begin
            push_err(cyc + 1);
        end
        send(c);
    endtask

    task automatic frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
        send(8'hA5);
        send(a);
        send(d);
        send_chk(a, d, c);
    endtask

    initial begin
        int c0;
        idle(2);
        chk("rst_duty_r", {24'd0, duty_r}, 32'h00);
        chk("rst_err_cnt", {24'd0, err_cnt}, 32'h00);
        chk("rst_pulses", {30'd0, cfg_update, frame_err}, 32'h0);
        rst_n = 1'b1;
        idle(2);

        // Reset mid-frame discards the partial frame
        send(8'hA5); send(8'h01);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
        send(8'h80); send(8'h81);
        idle(2);
        chk("midrst_duty_g", {24'd0, duty_g}, 32'h00);
        chk("midrst_err_cnt", {24'd0, err_cnt}, 32'h00);
        frame(8'h01, 8'h80, 8'h81);
        idle(2);

        // Per-channel writes
        frame(8'h00, 8'h11, 8'h11);
        frame(8'h01, 8'h22, 8'h23);
        frame(8'h02, 8'h33, 8'h31);
        idle(2);

        // Broadcast, then back-to-back frame with zero gap
        frame(8'h03, 8'h40, 8'h43);
        frame(8'h00, 8'hFF, 8'hFF);
        idle(2);

        // Bad checksum, bad address
        frame(8'h00, 8'h10, 8'hFF);
        send(8'hA5);
        push_err(cyc + 1);
        send(8'h07);
        idle(2);

        // Leading garbage, then resync with a doubled SYNC
        send(8'h12); send(8'h34);
        frame(8'h02, 8'h55, 8'h57);
        send(8'hA5); send(8'hA5); send(8'h02); send(8'h99);
        send_chk(8'h02, 8'h99, 8'h9B);
        idle(2);
        chk("mid_err_cnt", {24'd0, err_cnt}, {24'd0, m_ec});

        // Timeout after ADDR: error one cycle after T idle cycles pass the expiry check
        send(8'hA5);
        c0 = cyc;
        send(8'h01);
        push_err(c0 + T + 2);
        idle(T + 6);
        send(8'h80); send(8'h81);
        idle(2);
        chk("tmo_duty_g", {24'd0, duty_g}, {24'd0, m_g});

        // DATA lands on the expiry cycle: frame continues
        send(8'hA5); send(8'h01);
        idle(T);
        send(8'h6C);
        send_chk(8'h01, 8'h6C, 8'h6D);
        idle(2);

        // Saturation of err_cnt
        for (int i = 0; i < 260; i++) frame(8'h02, 8'h01, 8'h00);
        idle(3);
        chk("sat_err_cnt", {24'd0, err_cnt}, 32'hFF);
        chk("final_duty_r", {24'd0, duty_r}, {24'd0, m_r});
        chk("final_duty_b", {24'd0, duty_b}, {24'd0, m_b});
        chk("scoreboard_empty", q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rgb_cmd_ctrl.md
Name: rgb_cmd_ctrl

Overview:
Frame parser and configuration controller between the UART receiver and the RGB PWM stage. It consumes the received byte stream (byte plus one-cycle valid strobe) and decodes fixed 4-byte frames. It writes checksum-verified duty values into per-channel registers that drive the PWM duty inputs. It also discards malformed or stalled frames and counts errors.

Parameters:
CLK_HZ, 100_000_000, system clock frequency (informational; sets default timeout)
TIMEOUT_CYC, 100_000, max idle cycles between bytes inside a frame before abort (1 ms at 100 MHz)
SYNC_BYTE, 8'hA5, frame start marker
DUTY_RST, 8'h00, reset value of all three duty registers

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
command  input  8  received UART byte, valid only when rx_valid=1
rx_valid  input  1  one-cycle strobe per received byte
duty_r  output  8  red channel duty register
duty_g  output  8  green channel duty register
duty_b  output  8  blue channel duty register
cfg_update  output  1  one-cycle pulse when any duty register is written
frame_err  output  1  one-cycle pulse on a rejected frame
err_cnt  output  8  saturating count of rejected frames

Behaviour:
- Frame format: SYNC, ADDR, DATA, CHK, where CHK = ADDR ^ DATA.
- ADDR decode: 0x00 writes R, 0x01 writes G, 0x02 writes B, 0x03 writes all three with DATA.
- Reset (async assert, sync release): state=IDLE; duty_r/g/b=DUTY_RST; cfg_update=0; frame_err=0; err_cnt=0; timeout counter=0. Any partial frame is discarded.
- FSM states and transitions, evaluated only on cycles with rx_valid=1 unless noted:
  - IDLE: byte==SYNC_BYTE -> S_ADDR. Any other byte is ignored, with no error.
  - S_ADDR: byte<=0x03 latches addr -> S_DATA. byte==SYNC_BYTE restarts the frame: stay in S_ADDR, no error. Any other byte gives frame_err -> IDLE.
  - S_DATA: latches any byte as data (including 0xA5) -> S_CHK.
  - S_CHK: byte==addr^data performs the write -> IDLE. Mismatch gives frame_err -> IDLE, registers unchanged.
- Write latency: duty registers and cfg_update are registered on the same edge that samples the CHK strobe. New values are visible, and cfg_update is high, for the single cycle after the CHK byte's rx_valid cycle.
- cfg_update fires once per accepted frame, including ADDR=0x03.
- Timeout:
  - The counter runs only in S_ADDR/S_DATA/S_CHK.
  - It clears on every rx_valid and on entry to IDLE.
  - When it reaches TIMEOUT_CYC it forces frame_err and -> IDLE.
  - If rx_valid and timeout expiry coincide, rx_valid wins: the byte is processed normally and the counter clears.
- frame_err: one-cycle registered pulse, asserted in the cycle after the rejecting event. Each rejection increments err_cnt, which saturates at 8'hFF (no wrap).
- rx_valid held high for multiple cycles counts as multiple bytes. The block does not de-duplicate; UART must strobe.
- Back-to-back frames with zero gap cycles are accepted. A SYNC may arrive in the cycle immediately after a CHK.
- No combinational path from inputs to outputs.

Test Plan:
- Reset check: drive rst_n=0 mid-frame (after A5 01), release, then send 80 81 -> no write; duty_r/g/b=00, err_cnt=0, state IDLE. A following full frame A5 01 80 81 -> duty_g=0x80, cfg_update pulse x1.
- Per-channel writes: A5 00 11 11, A5 01 22 23, A5 02 33 31 -> duty_r=0x11, duty_g=0x22, duty_b=0x33; three cfg_update pulses, each exactly 1 cycle after its CHK strobe; err_cnt=0.
- Broadcast and back-to-back: A5 03 40 43 immediately followed by A5 00 FF FF with no gap -> after frame 1 all duties=0x40; after frame 2 duty_r=0xFF, g/b=0x40.
- Error paths:
  - A5 00 10 FF (bad CHK) -> frame_err pulse, err_cnt=1, duty_r unchanged.
  - A5 07 (bad ADDR) -> err_cnt=2.
  - Leading garbage 12 34 before a valid frame -> no error, frame accepted.
  - A5 A5 02 99 9B (resync) -> accepted, duty_b=0x99.
- Timeout: send A5 01, then idle TIMEOUT_CYC cycles -> frame_err exactly once, back to IDLE. Later bytes 80 81 -> ignored. Repeat with the DATA byte arriving on the expiry cycle -> frame continues, no error.
- Saturation: force 260 bad-CHK frames -> err_cnt stops at 0xFF and frame_err still pulses per frame.
